mem_xchg_engine: RTL

MEM_XCHG_ENGINE -- requirements
Module: mem_xchg_engine

---
 rtl/mem_xchg_pkg.sv | 16 +
 rtl/mem_regfile.sv | 45 ++++
 rtl/mem_xchg_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_xchg_pkg.sv
// Shared definitions for the memory exchange engine.
// Holds the command opcodes and the engine FSM state encoding.
package mem_xchg_pkg;

    localparam logic [1:0] OP_SWAP  = 2'b00;
    localparam logic [1:0] OP_COPY  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CAP  = 2'b01,
        WR_A = 2'b10,
        WR_B = 2'b11
    } state_t;

endpackage

// File: rtl/mem_regfile.sv
// Small register-file storage for the exchange engine.
// Ports:
//   clk, rst          clock and asynchronous active-high reset (clears all words)
//   w_en/w_addr/w_data single write port
//   a_addr -> a_data  combinational read port (operand A)
//   b_addr -> b_data  combinational read port (operand B)
//   r_addr -> r_data  combinational read port (external observation)
module mem_regfile
    import mem_xchg_pkg::*;
#(
    parameter int N    = 3,
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [N-1:0]    w_addr,
    input  logic [BITS-1:0] w_data,
    input  logic [N-1:0]    a_addr,
    output logic [BITS-1:0] a_data,
    input  logic [N-1:0]    b_addr,
    output logic [BITS-1:0] b_data,
    input  logic [N-1:0]    r_addr,
    output logic [BITS-1:0] r_data
);

    localparam int DEPTH = 1 << N;

    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign a_data = mem[a_addr];
    assign b_data = mem[b_addr];
    assign r_data = mem[r_addr];

endmodule

// File: rtl/mem_xchg_engine.sv
// Memory exchange engine: SWAP / COPY / CLEAR on a small register file.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   w_en, w_addr, w_data       external write, honoured only while idle
//   r_addr -> r_data           combinational read of the memory
//   cmd_valid, cmd_ready       command handshake (cmd_ready = ~busy)
//   cmd_op, A_addr, B_addr     opcode and operand addresses
//   busy                       command in progress
//   done, err                  one-cycle completion pulse / illegal opcode flag
//
// state | meaning
// IDLE  | waiting for a command, external writes allowed
// CAP   | capture tmp_a = mem[A], tmp_b = mem[B]; decode opcode
// WR_A  | write tmp_b (SWAP) or zero (CLEAR) to mem[A]
// WR_B  | write tmp_a to mem[B]
module mem_xchg_engine
    import mem_xchg_pkg::*;
#(
    parameter int N    = 3,
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_en,
    input  logic [N-1:0]    w_addr,
    input  logic [BITS-1:0] w_data,
    input  logic [N-1:0]    r_addr,
    output logic [BITS-1:0] r_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [N-1:0]    A_addr,
    input  logic [N-1:0]    B_addr,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t          state, state_next;
    logic [1:0]      op;
    logic [N-1:0]    addr_a, addr_b;
    logic [BITS-1:0] tmp_a, tmp_b;
    logic [BITS-1:0] rd_a, rd_b;
    logic            done_next, err_next;
    logic            accept;

    logic            fsm_we;
    logic [N-1:0]    fsm_addr;
    logic [BITS-1:0] fsm_data;

    logic            mem_we;
    logic [N-1:0]    mem_addr;
    logic [BITS-1:0] mem_data;

    assign busy      = (state != IDLE);
    assign cmd_ready = ~busy;
    assign accept    = cmd_valid && (state == IDLE);

    // The FSM only writes outside IDLE and external writes only land in IDLE,
    // so the two sources never compete for the port.
    assign mem_we   = fsm_we | (w_en & ~busy);
    assign mem_addr = fsm_we ? fsm_addr : w_addr;
    assign mem_data = fsm_we ? fsm_data : w_data;

    mem_regfile #(
        .N    (N),
        .BITS (BITS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .w_en   (mem_we),
        .w_addr (mem_addr),
        .w_data (mem_data),
        .a_addr (addr_a),
        .a_data (rd_a),
        .b_addr (addr_b),
        .b_data (rd_b),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op     <= OP_SWAP;
            addr_a <= '0;
            addr_b <= '0;
            tmp_a  <= '0;
            tmp_b  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            err   <= err_next;
            if (accept) begin
                op     <= cmd_op;
                addr_a <= A_addr;
                addr_b <= B_addr;
            end
            // Capturing both operands before any write keeps A==B and SWAP safe.
            if (state == CAP) begin
                tmp_a <= rd_a;
                tmp_b <= rd_b;
            end
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        err_next   = 1'b0;
        fsm_we     = 1'b0;
        fsm_addr   = addr_a;
        fsm_data   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                case (op)
                    OP_SWAP:  state_next = WR_A;
                    OP_CLEAR: state_next = WR_A;
                    OP_COPY:  state_next = WR_B;
                    default: begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end
                endcase
            end
            WR_A: begin
                fsm_we   = 1'b1;
                fsm_addr = addr_a;
                fsm_data = (op == OP_SWAP) ? tmp_b : '0;
                if (op == OP_SWAP) begin
                    state_next = WR_B;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            WR_B: begin
                fsm_we     = 1'b1;
                fsm_addr   = addr_b;
                fsm_data   = tmp_a;
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
